i2s_frame_sequencer: RTL

- Controller between the external audio codec serial port and the effects datapath.
- Synchronizes the codec's BCLK, LRCLK and ADC data into the system clock domain using three instances of the team's `synchronizer`, and uses their edge strobes to sequence I2S slots.
- Deserializes stereo ADC frames into a valid/ready output; serializes stereo DAC samples captured once per frame.

---
 rtl/i2s_pkg.sv | 14 +
 rtl/i2s_shift_lane.sv | 33 +++
 rtl/synchronizer.sv | 32 +++
 rtl/i2s_frame_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared state encoding, default geometry and stereo frame type for the I2S frame sequencer.
package i2s_pkg;

   localparam int DEF_SAMPLE_W = 24;
   localparam int DEF_SLOT_W   = 32;

   typedef enum logic [1:0] {SYNC, LEFT, RIGHT} i2s_state_t;

   typedef struct packed {
      logic [DEF_SAMPLE_W-1:0] left;
      logic [DEF_SAMPLE_W-1:0] right;
   } stereo_frame_t;

endpackage

// File: rtl/i2s_shift_lane.sv
// SAMPLE_W-bit shift register with parallel load, serial shift-in at the LSB and MSB shift-out.
// When load and shift coincide, the loaded word is shifted once in the same cycle.
module i2s_shift_lane
   import i2s_pkg::*;
#(
   parameter int SAMPLE_W = DEF_SAMPLE_W
) (
   input  logic                clock,
   input  logic                resetN,
   input  logic                load,
   input  logic [SAMPLE_W-1:0] loadValue,
   input  logic                shift,
   input  logic                shiftIn,
   output logic [SAMPLE_W-1:0] q,
   output logic                msbOut
);

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         q <= '0;
      end else if (load && shift) begin
         q <= {loadValue[SAMPLE_W-2:0], shiftIn};
      end else if (load) begin
         q <= loadValue;
      end else if (shift) begin
         q <= {q[SAMPLE_W-2:0], shiftIn};
      end
   end

   // The bit leaving the lane this cycle, including a word being loaded right now
   assign msbOut = load ? loadValue[SAMPLE_W-1] : q[SAMPLE_W-1];

endmodule

// File: rtl/synchronizer.sv
// Two-flop synchronizer for one asynchronous pin, with registered rise/fall strobes.
// A pin transition shows up on the strobes three clocks later; level is aligned with the strobes.
module synchronizer (
   input  logic clock,
   input  logic resetN,
   input  logic din,
   output logic level,
   output logic riseEdge,
   output logic fallEdge
);

   logic meta;
   logic stable;

   // meta/stable form the synchronizer chain; level is the previous stable value used for edge detection
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         meta     <= 1'b0;
         stable   <= 1'b0;
         level    <= 1'b0;
         riseEdge <= 1'b0;
         fallEdge <= 1'b0;
      end else begin
         meta     <= din;
         stable   <= meta;
         level    <= stable;
         riseEdge <= stable & ~level;
         fallEdge <= ~stable & level;
      end
   end

endmodule

// File: rtl/i2s_frame_sequencer.sv
// I2S slot sequencer between the codec serial port and the effects datapath.
// Optional build macro FRAME_ERR_CNT_EN adds an 8-bit saturating frame-error counter output errCount.
module i2s_frame_sequencer
   import i2s_pkg::*;
#(
   parameter int SAMPLE_W = DEF_SAMPLE_W,
   parameter int SLOT_W   = DEF_SLOT_W
) (
   input  logic                clock,
   input  logic                resetN,
   input  logic                bclk,
   input  logic                lrclk,
   input  logic                adcDat,
   output logic                dacDat,
   output logic [SAMPLE_W-1:0] rxLeft,
   output logic [SAMPLE_W-1:0] rxRight,
   output logic                rxValid,
   input  logic                rxReady,
   input  logic [SAMPLE_W-1:0] txLeft,
   input  logic [SAMPLE_W-1:0] txRight,
   output logic                txLoad,
   output logic                overrun,
   output logic                frameErr,
`ifdef FRAME_ERR_CNT_EN
   output logic [7:0]          errCount,
`endif
   input  logic                clearErr
);

   localparam int CNT_W = $clog2(SLOT_W + 2);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_SLOT = CNT_W'(SLOT_W);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_W);

   logic bRise, bFall, lrRise, lrFall, adcBit;
   logic bclkLevelUnused, lrLevelUnused, adcRiseUnused, adcFallUnused;

   synchronizer bclkSync (.clock(clock), .resetN(resetN), .din(bclk),
                          .level(bclkLevelUnused), .riseEdge(bRise), .fallEdge(bFall));
   synchronizer lrSync   (.clock(clock), .resetN(resetN), .din(lrclk),
                          .level(lrLevelUnused), .riseEdge(lrRise), .fallEdge(lrFall));
   synchronizer adcSync  (.clock(clock), .resetN(resetN), .din(adcDat),
                          .level(adcBit), .riseEdge(adcRiseUnused), .fallEdge(adcFallUnused));

   i2s_state_t          state;
   logic [CNT_W-1:0]    bitCnt;
   logic [SAMPLE_W-1:0] shadowLeft, shadowRight;
   logic [SAMPLE_W-1:0] rxLeftLane, rxRightLane, txLoadValue, txLaneUnused;
   logic                rxLeftMsbUnused, rxRightMsbUnused;
   logic                lrEdge, slotFull, dataRise, syncStart, slotErr, txActiveNext, txMsb;

   assign lrEdge    = lrRise | lrFall;
   assign slotFull  = (bitCnt == CNT_SLOT);
   assign syncStart = (state == SYNC) && lrFall;
   assign slotErr   = ((state == LEFT)  && lrRise && !slotFull) ||
                      ((state == RIGHT) && lrFall && !slotFull);
   assign txActiveNext = ((state != SYNC) && !slotErr) || syncStart;

   // Rise 1 of a slot is the I2S delay bit; rises 2..SAMPLE_W+1 carry data
   assign dataRise = bRise && !lrEdge && (bitCnt >= CNT_ONE) && (bitCnt <= CNT_LAST);

   // A left slot starting from a running frame sends the word captured at this very edge
   assign txLoadValue = !lrFall         ? shadowRight :
                        (state == RIGHT) ? txLeft      : shadowLeft;

   i2s_shift_lane #(.SAMPLE_W(SAMPLE_W)) rxLeftShift (
      .clock(clock), .resetN(resetN), .load(lrFall), .loadValue('0),
      .shift(dataRise && (state == LEFT)), .shiftIn(adcBit),
      .q(rxLeftLane), .msbOut(rxLeftMsbUnused));

   i2s_shift_lane #(.SAMPLE_W(SAMPLE_W)) rxRightShift (
      .clock(clock), .resetN(resetN), .load(lrRise), .loadValue('0),
      .shift(dataRise && (state == RIGHT)), .shiftIn(adcBit),
      .q(rxRightLane), .msbOut(rxRightMsbUnused));

   i2s_shift_lane #(.SAMPLE_W(SAMPLE_W)) txShift (
      .clock(clock), .resetN(resetN), .load(lrEdge), .loadValue(txLoadValue),
      .shift(bFall), .shiftIn(1'b0),
      .q(txLaneUnused), .msbOut(txMsb));

   // Slot sequencing, frame hand-off, error flags and DAC bit output
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state       <= SYNC;
         bitCnt      <= '0;
         shadowLeft  <= '0;
         shadowRight <= '0;
         rxLeft      <= '0;
         rxRight     <= '0;
         rxValid     <= 1'b0;
         txLoad      <= 1'b0;
         dacDat      <= 1'b0;
         overrun     <= 1'b0;
         frameErr    <= 1'b0;
      end else begin
         txLoad <= 1'b0;

         if (lrEdge) begin
            bitCnt <= bRise ? CNT_ONE : '0;
         end else if (bRise && (bitCnt != CNT_MAX)) begin
            bitCnt <= bitCnt + 1'b1;
         end

         if (!txActiveNext) begin
            dacDat <= 1'b0;
         end else if (bFall) begin
            dacDat <= txMsb;
         end

         if (rxValid && rxReady) begin
            rxValid <= 1'b0;
         end

         // Flags set further down override a same-cycle clear
         if (clearErr) begin
            overrun  <= 1'b0;
            frameErr <= 1'b0;
         end

         case (state)
            SYNC: begin
               if (lrFall) begin
                  state <= LEFT;
               end
            end
            LEFT: begin
               if (lrRise) begin
                  if (slotFull) begin
                     state <= RIGHT;
                  end else begin
                     state    <= SYNC;
                     frameErr <= 1'b1;
                  end
               end
            end
            RIGHT: begin
               if (lrFall) begin
                  txLoad      <= 1'b1;
                  shadowLeft  <= txLeft;
                  shadowRight <= txRight;
                  if (!slotFull) begin
                     state    <= SYNC;
                     frameErr <= 1'b1;
                  end else begin
                     state <= LEFT;
                     if (rxValid && !rxReady) begin
                        overrun <= 1'b1;
                     end else begin
                        rxLeft  <= rxLeftLane;
                        rxRight <= rxRightLane;
                        rxValid <= 1'b1;
                     end
                  end
               end
            end
            default: state <= SYNC;
         endcase
      end
   end

`ifdef FRAME_ERR_CNT_EN
   // Saturating count of frame errors; a new error beats a same-cycle clear
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         errCount <= 8'd0;
      end else if (slotErr) begin
         if (errCount != 8'hFF) begin
            errCount <= errCount + 8'd1;
         end
      end else if (clearErr) begin
         errCount <= 8'd0;
      end
   end
`endif

endmodule
